lcd_fb_sched: RTL

Triple-buffer frame scheduler for the LCD frame buffer.
- Generates write addresses and bank selection for the incoming PPU pixel stream.
- Publishes completed frames and hands the newest complete frame to the video scan-out at each output frame start.
- Sits between the PPU pixel stream and the frame-buffer RAM, in the clk_sys domain. The scan-out frame request arrives already synchronised.

---
 rtl/lcd_fb_pkg.sv | 23 ++
 rtl/lcd_fb_bank_rot.sv | 48 ++++
 rtl/lcd_fb_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lcd_fb_pkg.sv
// rtl/lcd_fb_pkg.sv - shared types and constants for the LCD frame-buffer scheduler
package lcd_fb_pkg;

    localparam int H_PIX  = 160;
    localparam int V_PIX  = 144;
    localparam int FPIX   = H_PIX * V_PIX;
    localparam int NBANKS = 3;

    typedef logic [1:0] bank_t;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SKIP   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_VBL    = 2'd3
    } state_t;

    // Banks 0,1,2 sum to 3, so the third bank is whatever the other two leave over.
    function automatic bank_t free_bank(input bank_t a, input bank_t b);
        return bank_t'(2'(NBANKS) - a - b);
    endfunction

endpackage

// File: rtl/lcd_fb_bank_rot.sv
// rtl/lcd_fb_bank_rot.sv - triple-buffer bank rotation: write, ready and display banks
module lcd_fb_bank_rot
    import lcd_fb_pkg::*;
(
    input  logic  clk_sys,
    input  logic  reset_n,
    input  logic  triple,
    input  logic  publish,
    input  logic  consume,
    input  logic  triple_reinit,
    output bank_t wr_bank,
    output bank_t disp
);

    bank_t ready;
    logic  ready_valid;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_bank     <= 2'd1;
            ready       <= 2'd0;
            ready_valid <= 1'b0;
            disp        <= 2'd0;
        end else if (triple_reinit) begin
            wr_bank     <= triple ? 2'd1 : 2'd0;
            ready       <= 2'd0;
            ready_valid <= 1'b0;
            disp        <= 2'd0;
        end else if (!triple) begin
            wr_bank     <= 2'd0;
            ready_valid <= 1'b0;
            disp        <= 2'd0;
        end else if (publish && consume) begin
            // The scan-out takes the frame just finished; writing moves to the bank neither side holds.
            disp        <= wr_bank;
            ready_valid <= 1'b0;
            wr_bank     <= free_bank(wr_bank, disp);
        end else if (publish) begin
            ready       <= wr_bank;
            ready_valid <= 1'b1;
            wr_bank     <= free_bank(wr_bank, disp);
        end else if (consume && ready_valid) begin
            disp        <= ready;
            ready_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lcd_fb_sched.sv
// rtl/lcd_fb_sched.sv - LCD frame scheduler: pixel write addressing, frame FSM and drop count
module lcd_fb_sched
    import lcd_fb_pkg::*;
#(
    parameter int H_PIX  = lcd_fb_pkg::H_PIX,
    parameter int V_PIX  = lcd_fb_pkg::V_PIX,
    parameter int ADDR_W = 15,
    parameter int DROP_W = 8
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                pix_wr,
    input  logic [14:0]         pix_data,
    input  logic                lcd_on,
    input  logic                vblank,
    input  logic                triple,
    input  logic                rd_frame_req,
    output logic                wr_en,
    output logic [ADDR_W+1:0]   wr_addr,
    output logic [14:0]         wr_data,
    output logic [1:0]          rd_bank,
    output logic                rd_frame_ack,
    output logic                rd_blank,
    output logic [DROP_W-1:0]   drop_cnt
);

    localparam int FPIX_L = H_PIX * V_PIX;
    // One spare bit so ptr can sit at FPIX even when FPIX == 2**ADDR_W.
    localparam int PTR_W  = ADDR_W + 1;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic             vblank_q;
    logic             triple_q;
    bank_t            wr_bank;
    bank_t            disp;

    logic triple_reinit;
    logic vbl_rise;
    logic vbl_fall;
    logic accept;
    logic frame_end;
    logic frame_full;
    logic publish;

    assign triple_reinit = (triple != triple_q);
    assign vbl_rise      = vblank & ~vblank_q;
    assign vbl_fall      = ~vblank & vblank_q;
    assign accept        = pix_wr && (state == ST_SKIP || state == ST_ACTIVE)
                           && (ptr < PTR_W'(FPIX_L));
    assign frame_end     = lcd_on && (state == ST_ACTIVE) && vbl_rise;
    assign frame_full    = (ptr == PTR_W'(FPIX_L));
    assign publish       = frame_end && triple && frame_full;
    assign rd_bank       = disp;

    lcd_fb_bank_rot u_bank_rot (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .triple        (triple),
        .publish       (publish),
        .consume       (rd_frame_req),
        .triple_reinit (triple_reinit),
        .wr_bank       (wr_bank),
        .disp          (disp)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state        <= ST_OFF;
            ptr          <= '0;
            vblank_q     <= 1'b0;
            triple_q     <= 1'b1;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            rd_frame_ack <= 1'b0;
            rd_blank     <= 1'b1;
            drop_cnt     <= '0;
        end else begin
            vblank_q     <= vblank;
            triple_q     <= triple;
            wr_en        <= accept;
            wr_addr      <= {wr_bank, ptr[ADDR_W-1:0]};
            wr_data      <= pix_data;
            rd_frame_ack <= rd_frame_req;

            if (rd_frame_req)
                rd_blank <= (state == ST_OFF) || (state == ST_SKIP);

            if (frame_end && !frame_full && (drop_cnt != '1))
                drop_cnt <= drop_cnt + DROP_W'(1);

            if (accept)
                ptr <= ptr + PTR_W'(1);

            if (!lcd_on) begin
                state <= ST_OFF;
                ptr   <= '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        state <= ST_SKIP;
                        ptr   <= '0;
                    end
                    ST_SKIP, ST_ACTIVE: begin
                        if (vbl_rise) begin
                            state <= ST_VBL;
                            ptr   <= '0;
                        end
                    end
                    ST_VBL: begin
                        if (vbl_fall)
                            state <= ST_ACTIVE;
                    end
                    default: state <= ST_OFF;
                endcase
            end

            if (triple_reinit)
                ptr <= '0;
        end
    end

endmodule
